// File: rtl/juego_boton_debounce_if.sv
// Button/game-core boundary for juego_boton_debounce: raw buttons in, press pulses and levels out.
// The board side uses master; the debouncer uses slave.
interface juego_boton_debounce_if;
    logic BotonA;
    logic BotonB;
    logic PulsoA;
    logic PulsoB;
    logic NivelA;
    logic NivelB;

    modport master (
        output BotonA, BotonB,
        input  PulsoA, PulsoB, NivelA, NivelB
    );

    modport slave (
        input  BotonA, BotonB,
        output PulsoA, PulsoB, NivelA, NivelB
    );
endinterface

// File: rtl/juego_boton_debounce.sv
// Two-channel push-button synchroniser and debouncer feeding the LED game core.
// Optional macro BOTON_EXCLUSIVE_EN: when both channels commit a press together, only PulsoA fires.
module juego_boton_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,  // >= 2
    parameter int CNT_W           = 20  // 2**CNT_W > DEBOUNCE_CYCLES
) (
    input  logic                  clock,
    input  logic                  Reset,
    juego_boton_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        PRESSED,
        CHK_REL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel 0 is A, channel 1 is B throughout.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    state_t           state_q   [2];
    state_t           state_nx  [2];
    logic [CNT_W-1:0] cnt_q     [2];
    logic [CNT_W-1:0] cnt_nx    [2];
    logic [1:0]       nivel_q;
    logic [1:0]       nivel_nx;
    logic [1:0]       pulso_q;
    logic [1:0]       pulso_hit;
    logic [1:0]       pulso_nx;

    assign raw = {bus.BotonB, bus.BotonA};

    // NOTE: every register below uses non-blocking assignment so all flops
    // sample the values from before the edge; blocking here would collapse
    // the two-flop synchroniser into a single stage.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
            nivel_q <= '0;
            pulso_q <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_nx[ch];
                cnt_q[ch]   <= cnt_nx[ch];
            end
            nivel_q <= nivel_nx;
            pulso_q <= pulso_nx;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred; the pulse default of 0 is what makes it one cycle.
        pulso_hit = '0;
        nivel_nx  = nivel_q;
        for (int ch = 0; ch < 2; ch++) begin
            state_nx[ch] = state_q[ch];
            cnt_nx[ch]   = cnt_q[ch];

            unique case (state_q[ch])
                IDLE: begin
                    if (sync2[ch]) begin
                        state_nx[ch] = CHK_PRESS;
                        cnt_nx[ch]   = CNT_ONE;
                    end else begin
                        cnt_nx[ch]   = '0;
                    end
                end
                CHK_PRESS: begin
                    if (!sync2[ch]) begin
                        state_nx[ch] = IDLE;
                        cnt_nx[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        state_nx[ch]  = PRESSED;
                        cnt_nx[ch]    = '0;
                        nivel_nx[ch]  = 1'b1;
                        pulso_hit[ch] = 1'b1;
                    end else begin
                        cnt_nx[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2[ch]) begin
                        state_nx[ch] = CHK_REL;
                        cnt_nx[ch]   = CNT_ONE;
                    end
                end
                CHK_REL: begin
                    // A bounce back high during release is not a new press.
                    if (sync2[ch]) begin
                        state_nx[ch] = PRESSED;
                        cnt_nx[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        state_nx[ch] = IDLE;
                        cnt_nx[ch]   = '0;
                        nivel_nx[ch] = 1'b0;
                    end else begin
                        cnt_nx[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_nx[ch] = IDLE;
                    cnt_nx[ch]   = '0;
                end
            endcase
        end

`ifdef BOTON_EXCLUSIVE_EN
        // B's simultaneous pulse is dropped, not deferred; its level still commits.
        pulso_nx = {pulso_hit[1] & ~pulso_hit[0], pulso_hit[0]};
`else
        pulso_nx = pulso_hit;
`endif
    end

    assign bus.PulsoA = pulso_q[0];
    assign bus.PulsoB = pulso_q[1];
    assign bus.NivelA = nivel_q[0];
    assign bus.NivelB = nivel_q[1];

endmodule

// File: tb/tb_juego_boton_debounce.sv
// Self-checking bench for juego_boton_debounce: directed table plus randomized bouncing
// buttons checked every cycle against a run-length reference model.
module tb_juego_boton_debounce;

    localparam int DC = 4;

    typedef struct {
        string    name;
        bit       rst_n;
        bit       a;
        bit       b;
        int       cycles;
        bit [3:0] exp;    // {PulsoA, PulsoB, NivelA, NivelB} after the last edge
    } vec_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    juego_boton_debounce_if bus ();

    juego_boton_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (20)
    ) dut (
        .clock(clock),
        .Reset(reset_n),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    // Reference model: a raw level reaches the debouncer two edges late, and the
    // debounced level flips once DC consecutive samples disagree with it.
    bit m_p1 [2];
    bit m_p2 [2];
    bit m_lvl [2];
    bit m_pulse [2];
    int m_run [2];

    function automatic void model_edge(bit rst_n, bit a, bit b);
        bit rawv [2];
        rawv[0] = a;
        rawv[1] = b;
        for (int ch = 0; ch < 2; ch++) begin
            if (!rst_n) begin
                m_p1[ch] = 0; m_p2[ch] = 0; m_lvl[ch] = 0; m_pulse[ch] = 0; m_run[ch] = 0;
            end else begin
                m_pulse[ch] = 0;
                if (m_p2[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DC) begin
                        m_lvl[ch]   = m_p2[ch];
                        m_pulse[ch] = m_p2[ch];
                        m_run[ch]   = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                m_p2[ch] = m_p1[ch];
                m_p1[ch] = rawv[ch];
            end
        end
`ifdef BOTON_EXCLUSIVE_EN
        if (m_pulse[0]) m_pulse[1] = 0;
`endif
    endfunction

    task automatic check(input string name, input bit [3:0] got, input bit [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got {PA,PB,NA,NB}=%b required %b", name, $time, got, exp);
        end
    endtask

    function automatic bit [3:0] dut_outs();
        return {bus.PulsoA, bus.PulsoB, bus.NivelA, bus.NivelB};
    endfunction

    // One clock edge with the given inputs, then compare DUT against the model.
    task automatic apply(input string name, input bit rst_n, input bit a, input bit b);
        reset_n    = rst_n;
        bus.BotonA = a;
        bus.BotonB = b;
        model_edge(rst_n, a, b);
        @(posedge clock);
        #1;
        check({name, "_model"}, dut_outs(), {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1]});
    endtask

    vec_t vecs[$];

    task automatic add(input string name, input bit rst_n, input bit a, input bit b,
                       input int cycles, input bit [3:0] exp);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.a = a; v.b = b; v.cycles = cycles; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        bit [3:0] both_exp;
        bit       ra;
        bit       rb;
        bit       rr;
        int       hold_a;
        int       hold_b;

        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        bus.BotonA = 1'b0;
        bus.BotonB = 1'b0;

`ifdef BOTON_EXCLUSIVE_EN
        both_exp = 4'b1011;
`else
        both_exp = 4'b1111;
`endif

        add("reset",             0, 0, 0,   2, 4'b0000);
        add("idle_quiet",        1, 0, 0, 100, 4'b0000);
        add("press_a_wait",      1, 1, 0,   5, 4'b0000);
        add("press_a_pulse",     1, 1, 0,   1, 4'b1010);
        add("press_a_once",      1, 1, 0,   1, 4'b0010);
        add("press_a_held",      1, 1, 0,  17, 4'b0010);
        add("rel_glitch",        1, 0, 0,   3, 4'b0010);
        add("rel_glitch_hold",   1, 1, 0,  10, 4'b0010);
        add("release_a_wait",    1, 0, 0,   5, 4'b0010);
        add("release_a_level",   1, 0, 0,   1, 4'b0000);
        add("release_a_quiet",   1, 0, 0,  14, 4'b0000);
        add("bounce_1",          1, 1, 0,   1, 4'b0000);
        add("bounce_0",          1, 0, 0,   1, 4'b0000);
        add("bounce_1b",         1, 1, 0,   1, 4'b0000);
        add("bounce_0b",         1, 0, 0,   1, 4'b0000);
        add("bounce_quiet",      1, 0, 0,  20, 4'b0000);
        add("short_press",       1, 1, 0,   3, 4'b0000);
        add("short_press_rej",   1, 0, 0,  10, 4'b0000);
        add("press_b_wait",      1, 0, 1,   5, 4'b0000);
        add("press_b_pulse",     1, 0, 1,   1, 4'b0101);
        add("press_b_once",      1, 0, 1,   1, 4'b0001);
        add("release_b_wait",    1, 0, 0,   5, 4'b0001);
        add("release_b_level",   1, 0, 0,   1, 4'b0000);
        add("both_wait",         1, 1, 1,   5, 4'b0000);
        add("both_pulse",        1, 1, 1,   1, both_exp);
        add("both_once",         1, 1, 1,   1, 4'b0011);
        add("both_release",      1, 0, 0,   6, 4'b0000);
        add("pre_reset",         1, 1, 0,   4, 4'b0000);
        add("in_reset",          0, 1, 0,   2, 4'b0000);
        add("post_reset_wait",   1, 1, 0,   5, 4'b0000);
        add("post_reset_pulse",  1, 1, 0,   1, 4'b1010);
        add("post_reset_once",   1, 1, 0,   1, 4'b0010);
        add("post_reset_rel",    1, 0, 0,   6, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].cycles; c++)
                apply(vecs[i].name, vecs[i].rst_n, vecs[i].a, vecs[i].b);
            check(vecs[i].name, dut_outs(), vecs[i].exp);
        end

        // Random bouncing buttons with occasional resets.
        ra = 0; rb = 0; hold_a = 0; hold_b = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_a == 0) begin
                ra     = $urandom_range(0, 1) != 0;
                hold_a = $urandom_range(1, 9);
            end
            if (hold_b == 0) begin
                rb     = $urandom_range(0, 1) != 0;
                hold_b = $urandom_range(1, 9);
            end
            hold_a--;
            hold_b--;
            rr = $urandom_range(0, 299) != 0;
            apply("random", rr, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
